laser_hit_scorer: RTL and testbench
===================================

// Module: laser_hit_scorer
// PURPOSE
//  Downstream checker for the two-circle laser placement stage. Snoops the same 40-point X/Y
//  stream the placement stage loads, captures the C1/C2 centres when that stage raises DONE,
//  and scores them: counts points covered by the union of the two radius-4 circles.
//  Feeds the test harness and the host scoreboard with HIT_CNT / OVL_CNT plus a valid strobe.
// PARAMETERS
//  NUM_PTS      40  points per frame
//  PTS_PER_CYC  4   points scored per SCORE cycle (NUM_PTS need not be a multiple)
//  RADIUS_SQ    16  inclusive coverage threshold on squared distance
// PORTS
//  CLK      in   1  single clock, all state on rising edge
//  RST_N    in   1  asynchronous, active-low reset
//  START    in   1  frame start; point 0 is on X/Y in the same cycle
//  X        in   4  target x, one point per cycle during load
//  Y        in   4  target y, one point per cycle during load
//  DONE_IN  in   1  placement stage DONE (level; may stay high)
//  C1X,C1Y  in   4  circle-1 centre, valid while DONE_IN=1
//  C2X,C2Y  in   4  circle-2 centre, valid while DONE_IN=1
//  BUSY     out  1  high in every state except IDLE
//  VALID    out  1  one-cycle strobe: HIT_CNT/OVL_CNT are final
//  HIT_CNT  out  6  points inside circle 1 OR circle 2
//  OVL_CNT  out  6  points inside circle 1 AND circle 2
// BEHAVIOUR
//  Reset (RST_N=0, async): state=IDLE; BUSY=0, VALID=0, HIT_CNT=0, OVL_CNT=0; point buffer cleared.
//  States: IDLE -> LOAD -> WAIT -> SCORE -> REPORT -> IDLE.
//  IDLE: START=1 stores X/Y as point 0, index=1, go LOAD. START outside IDLE is ignored.
//  LOAD: store X/Y at index each cycle. When point NUM_PTS-1 is stored, go WAIT.
//    Total load is exactly NUM_PTS cycles, counted from the START cycle.
//  WAIT: DONE_IN is sampled only here; DONE_IN high in IDLE/LOAD is ignored.
//    The first cycle with DONE_IN=1 latches C1X..C2Y, clears the accumulators, sets group=0, go SCORE.
//  SCORE: each cycle evaluates points group*PTS_PER_CYC .. +PTS_PER_CYC-1.
//    Indices >= NUM_PTS are masked (contribute 0).
//    Runs ceil(NUM_PTS/PTS_PER_CYC) cycles (10 at defaults), then go REPORT.
//  Arithmetic per point and centre:
//    dx=|cx-x|, dy=|cy-y|, each 4b unsigned with no wrap; dx*dx, dy*dy each 8b; d=sum, 9b.
//    in_k = (d <= RADIUS_SQ). Boundary point d==16 is covered.
//    HIT += in1|in2; OVL += in1&in2. Accumulators are 6b, max NUM_PTS, no saturation needed.
//  REPORT: HIT_CNT/OVL_CNT take the accumulator values, VALID=1 for exactly this cycle, go IDLE.
//    Outputs then hold until the next REPORT or reset.
//  Latency: DONE_IN sampled high in cycle t -> VALID in cycle t+11 at defaults.
//    In general t + ceil(NUM_PTS/PTS_PER_CYC) + 1.
//  A START in the same cycle as REPORT is ignored. The earliest new frame is the cycle after VALID.
//  Coincident centres (C1==C2): HIT_CNT==OVL_CNT.
//  Reset mid-frame aborts immediately. No VALID is produced, and the next frame needs a fresh START.
// STRUCTURE
//  Shared package laser_pkg:
//    COORD_W=4, NUM_PTS=40, RADIUS_SQ=16
//    state encoding localparams ST_IDLE..ST_REPORT
//    typedef point_t {x,y} (4b each)
//  Sub-module laser_dist_chk (combinational):
//    inputs: centre, point; output: in_circle (d<=RADIUS_SQ)
//    instantiated 2*PTS_PER_CYC times
//  Top: FSM, 40-entry point buffer, group counter, popcount adders.
// TESTING
//  1 All 40 points (8,8); C1=(8,8), C2=(0,0) -> HIT=40, OVL=0; VALID 11 cycles after DONE_IN.
//  2 Points (8,4),(12,8),(8,12),(4,8) x10 (d=16); C1=C2=(8,8) -> HIT=40, OVL=40 (inclusive edge).
//  3 Points (0,0) x20 plus (15,15) x20; C1=(0,0), C2=(15,15) -> HIT=40, OVL=0 (no abs-diff wrap).
//  4 Points (5,5) x40; C1=(10,10), C2=(0,0) (d=50 each) -> HIT=0, OVL=0.
//  5 DONE_IN high during LOAD, and START pulsed in WAIT -> both ignored.
//    Scoring starts only on DONE_IN sampled in WAIT; one VALID pulse per frame.
//  6 RST_N low at load cycle 20 -> outputs 0 at once, asynchronously.
//    A fresh frame after release scores correctly with the default counts.
//  7 Parameter sweep: PTS_PER_CYC=3 -> 14 SCORE cycles; same counts as the default run (masking check).

Source files
------------

// File: rtl/laser_hit_scorer_pkg.sv
// Shared widths, state encoding and point type for the laser hit scorer.
package laser_pkg;

  localparam int unsigned COORD_W   = 4;
  localparam int unsigned NUM_PTS   = 40;
  localparam int unsigned RADIUS_SQ = 16;
  localparam int unsigned CNT_W     = 6;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_WAIT   = 3'd2;
  localparam state_t ST_SCORE  = 3'd3;
  localparam state_t ST_REPORT = 3'd4;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

endpackage

// File: rtl/laser_hit_scorer_if.sv
// Point stream, placement centres and score results between harness and scorer.
interface laser_hit_scorer_if;
  import laser_pkg::*;

  logic               start;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               done_in;
  logic [COORD_W-1:0] c1x;
  logic [COORD_W-1:0] c1y;
  logic [COORD_W-1:0] c2x;
  logic [COORD_W-1:0] c2y;
  logic               busy;
  logic               valid;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   ovl_cnt;

  modport master (
    output start, x, y, done_in, c1x, c1y, c2x, c2y,
    input  busy, valid, hit_cnt, ovl_cnt
  );

  modport slave (
    input  start, x, y, done_in, c1x, c1y, c2x, c2y,
    output busy, valid, hit_cnt, ovl_cnt
  );

endinterface

// File: rtl/laser_hit_scorer_dist_chk.sv
// Combinational test of whether a point lies within RADIUS_SQ of a centre.
module laser_dist_chk
  import laser_pkg::*;
(
  input  point_t centre,
  input  point_t point,
  output logic   in_circle
);

  logic [COORD_W-1:0]   dx;
  logic [COORD_W-1:0]   dy;
  logic [2*COORD_W-1:0] dx2;
  logic [2*COORD_W-1:0] dy2;
  logic [2*COORD_W:0]   d;

  // Absolute differences ordered to avoid modular wrap.
  assign dx  = (centre.x >= point.x) ? (centre.x - point.x) : (point.x - centre.x);
  assign dy  = (centre.y >= point.y) ? (centre.y - point.y) : (point.y - centre.y);
  assign dx2 = (2*COORD_W)'(dx) * (2*COORD_W)'(dx);
  assign dy2 = (2*COORD_W)'(dy) * (2*COORD_W)'(dy);
  assign d   = (2*COORD_W+1)'(dx2) + (2*COORD_W+1)'(dy2);

  assign in_circle = (d <= (2*COORD_W+1)'(RADIUS_SQ));

endmodule

// File: rtl/laser_hit_scorer.sv
// Captures a frame of points and scores union/overlap coverage of two placed circles.
module laser_hit_scorer
  import laser_pkg::*;
#(
  parameter int unsigned PTS_PER_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  laser_hit_scorer_if.slave  bus
);

  localparam int unsigned NUM_GRP = (NUM_PTS + PTS_PER_CYC - 1) / PTS_PER_CYC;
  localparam int unsigned IDX_W   = $clog2(NUM_PTS);
  localparam int unsigned GRP_W   = $clog2(NUM_GRP + 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   wr_idx;
  logic [GRP_W-1:0]   grp_q;
  point_t             pts_q [NUM_PTS];
  point_t             c1_q, c2_q;
  logic [CNT_W-1:0]   hit_acc, ovl_acc;
  logic [CNT_W-1:0]   grp_hit, grp_ovl;
  logic [PTS_PER_CYC-1:0] in1, in2;

  logic store_pt, latch_c, score_en, last_grp;
  logic busy_d, valid_d;

  assign last_grp = (grp_q == GRP_W'(NUM_GRP - 1));
  assign wr_idx   = (state_q == ST_IDLE) ? '0 : idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_LOAD;
      ST_LOAD:   if (idx_q == IDX_W'(NUM_PTS - 1)) state_d = ST_WAIT;
      ST_WAIT:   if (bus.done_in) state_d = ST_SCORE;
      ST_SCORE:  if (last_grp) state_d = ST_REPORT;
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    store_pt = ((state_q == ST_IDLE) && bus.start) || (state_q == ST_LOAD);
    latch_c  = (state_q == ST_WAIT) && bus.done_in;
    score_en = (state_q == ST_SCORE);
    busy_d   = (state_d != ST_IDLE);
    valid_d  = (state_d == ST_REPORT);
  end

  // One lane per point scored in a cycle; lanes past the last point are masked.
  for (genvar l = 0; l < PTS_PER_CYC; l++) begin : g_lane
    logic [IDX_W:0] li;
    logic           ok;
    point_t         pt;
    logic           i1, i2;

    assign li = (IDX_W+1)'(32'(grp_q) * PTS_PER_CYC + l);
    assign ok = (li < (IDX_W+1)'(NUM_PTS));
    assign pt = ok ? pts_q[li[IDX_W-1:0]] : '0;

    laser_dist_chk u_chk1 (.centre(c1_q), .point(pt), .in_circle(i1));
    laser_dist_chk u_chk2 (.centre(c2_q), .point(pt), .in_circle(i2));

    assign in1[l] = ok & i1;
    assign in2[l] = ok & i2;
  end

  always_comb begin
    grp_hit = '0;
    grp_ovl = '0;
    for (int i = 0; i < PTS_PER_CYC; i++) begin
      grp_hit = grp_hit + CNT_W'(in1[i] | in2[i]);
      grp_ovl = grp_ovl + CNT_W'(in1[i] & in2[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PTS; i++) pts_q[i] <= '0;
      idx_q   <= '0;
      grp_q   <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      hit_acc <= '0;
      ovl_acc <= '0;
    end else begin
      if (store_pt) begin
        pts_q[wr_idx] <= {bus.x, bus.y};
        idx_q         <= wr_idx + IDX_W'(1);
      end
      if (latch_c) begin
        c1_q    <= {bus.c1x, bus.c1y};
        c2_q    <= {bus.c2x, bus.c2y};
        hit_acc <= '0;
        ovl_acc <= '0;
        grp_q   <= '0;
      end else if (score_en) begin
        hit_acc <= hit_acc + grp_hit;
        ovl_acc <= ovl_acc + grp_ovl;
        grp_q   <= grp_q + GRP_W'(1);
      end
    end
  end

  // Results are registered on entry to REPORT so they align with the valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy    <= 1'b0;
      bus.valid   <= 1'b0;
      bus.hit_cnt <= '0;
      bus.ovl_cnt <= '0;
    end else begin
      bus.busy  <= busy_d;
      bus.valid <= valid_d;
      if (valid_d) begin
        bus.hit_cnt <= hit_acc + grp_hit;
        bus.ovl_cnt <= ovl_acc + grp_ovl;
      end
    end
  end

endmodule

// File: tb/tb_laser_hit_scorer.sv
// Scoreboard bench: two scorers (4 and 3 points per cycle) fed the same frames.
module tb_laser_hit_scorer;
  import laser_pkg::*;

  typedef struct {
    int hit;
    int ovl;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, done_in;
  logic [3:0] x, y, c1x, c1y, c2x, c2y;

  int px [NUM_PTS];
  int py [NUM_PTS];
  exp_t qa[$];
  exp_t qb[$];
  int ec = 0;
  int n_cmp = 0, n_bad = 0;
  int va_cnt = 0, vb_cnt = 0, v_target = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  laser_hit_scorer_if ifa ();
  laser_hit_scorer_if ifb ();

  assign ifa.start = start;   assign ifb.start = start;
  assign ifa.x = x;           assign ifb.x = x;
  assign ifa.y = y;           assign ifb.y = y;
  assign ifa.done_in = done_in; assign ifb.done_in = done_in;
  assign ifa.c1x = c1x;       assign ifb.c1x = c1x;
  assign ifa.c1y = c1y;       assign ifb.c1y = c1y;
  assign ifa.c2x = c2x;       assign ifb.c2x = c2x;
  assign ifa.c2y = c2y;       assign ifb.c2y = c2y;

  laser_hit_scorer #(.PTS_PER_CYC(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  laser_hit_scorer #(.PTS_PER_CYC(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && ifa.valid) begin
      if (qa.size() == 0) check("a_unexpected_valid", 1, 0);
      else begin
        e = qa.pop_front();
        check("a_hit", int'(ifa.hit_cnt), e.hit);
        check("a_ovl", int'(ifa.ovl_cnt), e.ovl);
        check("a_valid_cycle", ec, e.cyc);
      end
      va_cnt++;
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && ifb.valid) begin
      if (qb.size() == 0) check("b_unexpected_valid", 1, 0);
      else begin
        e = qb.pop_front();
        check("b_hit", int'(ifb.hit_cnt), e.hit);
        check("b_ovl", int'(ifb.ovl_cnt), e.ovl);
        check("b_valid_cycle", ec, e.cyc);
      end
      vb_cnt++;
    end
  end

  task automatic set_pattern(input int k);
    for (int i = 0; i < NUM_PTS; i++) begin
      case (k)
        1: begin px[i] = 8; py[i] = 8; end
        2: case (i % 4)
             0: begin px[i] = 8;  py[i] = 4;  end
             1: begin px[i] = 12; py[i] = 8;  end
             2: begin px[i] = 8;  py[i] = 12; end
             default: begin px[i] = 4; py[i] = 8; end
           endcase
        3: begin px[i] = (i < 20) ? 0 : 15; py[i] = px[i]; end
        4: begin px[i] = 5; py[i] = 5; end
        default: begin px[i] = (i < 20) ? 6 : 1; py[i] = px[i]; end
      endcase
    end
  endtask

  // Loads one frame with decoy centres, then presents the real centres with DONE_IN.
  task automatic run_frame(input int k1x, input int k1y, input int k2x, input int k2y,
                           input int ex_hit, input int ex_ovl, input bit odd);
    int dcyc;
    int budget;
    c1x = 4'd15; c1y = 4'd0; c2x = 4'd0; c2y = 4'd15;
    @(negedge clk);
    start = 1'b1; x = 4'(px[0]); y = 4'(py[0]);
    for (int i = 1; i < NUM_PTS; i++) begin
      @(negedge clk);
      start = 1'b0; x = 4'(px[i]); y = 4'(py[i]);
      if (odd) done_in = (i >= 5 && i < 30);
    end
    @(negedge clk);
    x = 4'd0; y = 4'd0;
    if (odd) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
    end
    c1x = 4'(k1x); c1y = 4'(k1y); c2x = 4'(k2x); c2y = 4'(k2y);
    done_in = 1'b1;
    dcyc = ec;
    qa.push_back('{ex_hit, ex_ovl, dcyc + 11});
    qb.push_back('{ex_hit, ex_ovl, dcyc + 15});
    v_target++;
    budget = 0;
    while ((va_cnt < v_target || vb_cnt < v_target) && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    done_in = 1'b0;
    if (va_cnt < v_target || vb_cnt < v_target) begin
      check("valid_timeout", 0, 1);
      qa.delete(); qb.delete();
      va_cnt = v_target; vb_cnt = v_target;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; done_in = 1'b0;
    x = '0; y = '0; c1x = '0; c1y = '0; c2x = '0; c2y = '0;
    #22;
    check("rst_busy",  int'(ifa.busy), 0);
    check("rst_valid", int'(ifa.valid), 0);
    check("rst_hit",   int'(ifa.hit_cnt), 0);
    check("rst_ovl",   int'(ifb.ovl_cnt), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    set_pattern(1); run_frame(8, 8, 0, 0, 40, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_hit",   int'(ifa.hit_cnt), 40);
    check("hold_busy",  int'(ifa.busy), 0);
    check("hold_valid", int'(ifb.valid), 0);

    set_pattern(2); run_frame(8, 8, 8, 8, 40, 40, 1'b0);
    set_pattern(3); run_frame(0, 0, 15, 15, 40, 0, 1'b0);
    set_pattern(4); run_frame(10, 10, 0, 0, 0, 0, 1'b0);
    set_pattern(5); run_frame(8, 8, 4, 4, 20, 20, 1'b1);

    // Abort a frame mid-load and expect outputs to clear without a clock edge.
    set_pattern(1);
    @(negedge clk);
    start = 1'b1; x = 4'(px[0]); y = 4'(py[0]);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0; x = 4'(px[i]); y = 4'(py[i]);
    end
    check("pre_rst_busy", int'(ifa.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",  int'(ifa.busy), 0);
    check("arst_hit_a", int'(ifa.hit_cnt), 0);
    check("arst_ovl_a", int'(ifa.ovl_cnt), 0);
    check("arst_hit_b", int'(ifb.hit_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", int'(ifb.busy), 0);

    set_pattern(3); run_frame(0, 0, 8, 8, 20, 0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", qa.size() + qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
